// File: rtl/rr_stream_mux_if.sv
// Stream bundle for rr_stream_mux: N_CH producer channels in, one registered consumer stream out.
// The packet-lock last signals exist only when RR_STREAM_MUX_LOCK_EN is defined.
interface rr_stream_mux_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
);
    localparam int unsigned CH_W = $clog2(N_CH);

    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_ready;
`ifdef RR_STREAM_MUX_LOCK_EN
    logic [N_CH-1:0]   in_last;
    logic              out_last;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

    // Mux side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );
`else
    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Mux side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
`endif
endinterface

// File: rtl/rr_stream_mux.sv
// N_CH-to-1 round-robin stream mux with a one-entry registered output stage.
// Optional packet lock (keeps the grant on one channel until its last beat) via RR_STREAM_MUX_LOCK_EN.
module rr_stream_mux #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_stream_mux_if.slave bus
);
    localparam int unsigned CH_W = $clog2(N_CH);

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] ptr_next;
    int unsigned     scan_idx;
    logic            grant_vld;
    logic            can_load;
    logic            accept;
    logic            last_beat;
    logic [N_CH-1:0] ready_c;
    logic [W-1:0]    chan_data [N_CH];

    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [CH_W-1:0] out_ch_q;

`ifdef RR_STREAM_MUX_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_t;
    state_t          state;
    logic [CH_W-1:0] lock_ch;
    logic            out_last_q;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_split
        assign chan_data[i] = bus.in_data[i*W +: W];
    end

    // Fair grant: first valid channel at or after rr_ptr, wrapping modulo N_CH
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            scan_idx = 32'(rr_ptr) + k;
            if (scan_idx >= N_CH) begin
                scan_idx = scan_idx - N_CH;
            end
            cand = CH_W'(scan_idx);
            if (!grant_vld && bus.in_valid[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
`ifdef RR_STREAM_MUX_LOCK_EN
        // Mid-packet the owning channel keeps the grant even while it idles
        if (state == LOCKED) begin
            grant     = lock_ch;
            grant_vld = 1'b1;
        end
`endif
    end

    assign can_load = !out_valid_q || bus.out_ready;
    assign accept   = rst_n && grant_vld && can_load && bus.in_valid[grant];
    assign ptr_next = (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);

`ifdef RR_STREAM_MUX_LOCK_EN
    assign last_beat = bus.in_last[grant];
`else
    assign last_beat = 1'b1;
`endif

    always_comb begin
        ready_c = '0;
        if (rst_n && grant_vld) begin
            ready_c[grant] = can_load;
        end
    end

    assign bus.in_ready = ready_c;

    // Output register: load on input transfer, drain on output-only transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= chan_data[grant];
            out_ch_q    <= grant;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Pointer moves only past a completed unit (single beat, or packet end under lock)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && last_beat) begin
            rr_ptr <= ptr_next;
        end
    end

`ifdef RR_STREAM_MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB;
            lock_ch    <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (accept) begin
                out_last_q <= last_beat;
            end
            case (state)
                ARB: begin
                    if (accept && !last_beat) begin
                        state   <= LOCKED;
                        lock_ch <= grant;
                    end
                end
                LOCKED: begin
                    if (accept && last_beat) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign bus.out_last = out_last_q;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed vector table, randomized run against a reference model,
// and a packet-lock sequence when RR_STREAM_MUX_LOCK_EN is defined.
module tb_rr_stream_mux;
    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_stream_mux_if #(.N_CH(N_CH), .W(W)) bus ();
    rr_stream_mux #(.N_CH(N_CH), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_och;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic rst, logic [3:0] vld, logic [31:0] dat, logic ordy,
                                logic [3:0] e_rdy, logic e_ov, logic [7:0] e_od, logic [1:0] e_och);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_och = e_och;
        return v;
    endfunction

    // Reference model state: pointer plus contents of the one-entry output register
    int          m_ptr;
    logic        m_v;
    logic [7:0]  m_d;
    int          m_c;

    task automatic model_grant(input logic [3:0] vld, input logic ordy,
                               output logic [3:0] rdy, output int g, output bit acc);
        bit can_load;
        can_load = !m_v || ordy;
        g = -1;
        for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_ptr + k) % N_CH;
            if (g < 0 && vld[c]) g = c;
        end
        rdy = '0;
        acc = 0;
        if (g >= 0 && can_load) begin
            rdy = 4'(1 << g);
            acc = 1;
        end
    endtask

    task automatic model_edge(input logic [3:0] vld, input logic [31:0] dat, input logic ordy);
        logic [3:0] rdy;
        int g;
        bit acc;
        model_grant(vld, ordy, rdy, g, acc);
        if (acc) begin
            m_v   = 1'b1;
            m_d   = dat[g*8 +: 8];
            m_c   = g;
            m_ptr = (g + 1) % N_CH;
        end else if (m_v && ordy) begin
            m_v = 1'b0;
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] vld, input logic [31:0] dat, input logic ordy);
        rst_n         = rst;
        bus.in_valid  = vld;
        bus.in_data   = dat;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  p_vld;
    logic [31:0] p_dat;
    logic        p_ordy;

    initial begin
        // Table: reset hold, fairness sweep, single channel, backpressure, sparse/idle
        vecs[0]  = mk(0, 4'hF, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0);
        vecs[1]  = mk(0, 4'hF, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0);
        vecs[2]  = mk(0, 4'hF, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0);
        vecs[3]  = mk(1, 4'hF, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 0);
        vecs[4]  = mk(1, 4'hF, 32'hA3A2A1A0, 1, 4'b0010, 1, 8'hA1, 1);
        vecs[5]  = mk(1, 4'hF, 32'hA3A2A1A0, 1, 4'b0100, 1, 8'hA2, 2);
        vecs[6]  = mk(1, 4'hF, 32'hA3A2A1A0, 1, 4'b1000, 1, 8'hA3, 3);
        vecs[7]  = mk(1, 4'hF, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 0);
        vecs[8]  = mk(1, 4'b0100, 32'h005C0000, 1, 4'b0100, 1, 8'h5C, 2);
        vecs[9]  = mk(1, 4'b0000, 32'h005C0000, 1, 4'b0000, 0, 8'h5C, 2);
        vecs[10] = mk(1, 4'hF, 32'hA3A2A1A0, 0, 4'b1000, 1, 8'hA3, 3);
        vecs[11] = mk(1, 4'hF, 32'hA3A2A1A0, 0, 4'b0000, 1, 8'hA3, 3);
        vecs[12] = mk(1, 4'hF, 32'hA3A2A1A0, 0, 4'b0000, 1, 8'hA3, 3);
        vecs[13] = mk(1, 4'hF, 32'hA3A2A1A0, 0, 4'b0000, 1, 8'hA3, 3);
        vecs[14] = mk(1, 4'hF, 32'hA3A2A1A0, 0, 4'b0000, 1, 8'hA3, 3);
        vecs[15] = mk(1, 4'hF, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 0);
        vecs[16] = mk(1, 4'hF, 32'hA3A2A1A0, 1, 4'b0010, 1, 8'hA1, 1);
        vecs[17] = mk(1, 4'b1010, 32'hA3A2A1A0, 1, 4'b1000, 1, 8'hA3, 3);
        vecs[18] = mk(1, 4'b1010, 32'hA3A2A1A0, 1, 4'b0010, 1, 8'hA1, 1);
        vecs[19] = mk(1, 4'b0000, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'hA1, 1);
        vecs[20] = mk(1, 4'b0000, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'hA1, 1);
        vecs[21] = mk(1, 4'b1010, 32'hA3A2A1A0, 1, 4'b1000, 1, 8'hA3, 3);
        vecs[22] = mk(1, 4'b0000, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'hA3, 3);

`ifdef RR_STREAM_MUX_LOCK_EN
        bus.in_last = '1;
`endif
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
            tick();
            chk($sformatf("vec%0d_out", i), {21'b0, bus.out_valid, bus.out_data, bus.out_ch},
                {21'b0, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_och});
        end

        // Randomized run against the reference model, starting from a fresh reset
        drive(0, 4'h0, 32'h0, 1);
        tick();
        m_ptr = 0; m_v = 1'b0; m_d = 8'h00; m_c = 0;
        p_vld = '0;
        p_dat = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] e_rdy;
            logic [3:0] hs;
            int g;
            bit acc;
            p_ordy = ($urandom_range(0, 9) < 7);
            drive(1, p_vld, p_dat, p_ordy);
            #1;
            model_grant(p_vld, p_ordy, e_rdy, g, acc);
            chk("rand_in_ready", 32'(bus.in_ready), 32'(e_rdy));
            hs = bus.in_valid & bus.in_ready;
            model_edge(p_vld, p_dat, p_ordy);
            tick();
            chk("rand_out", {21'b0, bus.out_valid, bus.out_data, bus.out_ch},
                {21'b0, m_v, m_d, 2'(m_c)});
            // Producers hold valid/data until accepted, then may offer a new beat
            for (int c = 0; c < N_CH; c++) begin
                if (hs[c] || !p_vld[c]) begin
                    p_vld[c] = ($urandom_range(0, 2) != 0);
                    p_dat[c*8 +: 8] = 8'($urandom);
                end
            end
        end

`ifdef RR_STREAM_MUX_LOCK_EN
        // Packet lock: ch0 sends three beats while ch1 competes
        drive(0, 4'h0, 32'h0, 1);
        tick();
        bus.in_last = 4'b0010;
        drive(1, 4'b0011, 32'h0000_2010, 1);
        #1;
        chk("lock_b1_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("lock_b1_out", {22'b0, bus.out_last, bus.out_data, bus.out_ch}, {22'b0, 1'b0, 8'h10, 2'd0});
        drive(1, 4'b0011, 32'h0000_2011, 1);
        #1;
        chk("lock_b2_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("lock_b2_out", {22'b0, bus.out_last, bus.out_data, bus.out_ch}, {22'b0, 1'b0, 8'h11, 2'd0});
        bus.in_last = 4'b0011;
        drive(1, 4'b0011, 32'h0000_2012, 1);
        tick();
        chk("lock_b3_out", {22'b0, bus.out_last, bus.out_data, bus.out_ch}, {22'b0, 1'b1, 8'h12, 2'd0});
        drive(1, 4'b0011, 32'h0000_2013, 1);
        tick();
        chk("lock_ch1_out", {22'b0, bus.out_last, bus.out_data, bus.out_ch}, {22'b0, 1'b1, 8'h20, 2'd1});
        // Open a new ch0 packet, then reset mid-packet
        bus.in_last = 4'b0010;
        drive(1, 4'b0011, 32'h0000_2014, 1);
        tick();
        chk("lock_reopen_out", {22'b0, bus.out_last, bus.out_data, bus.out_ch}, {22'b0, 1'b0, 8'h14, 2'd0});
        drive(0, 4'b0011, 32'h0000_2014, 1);
        tick();
        chk("lock_rst_out", {22'b0, bus.out_valid, bus.out_last, bus.out_data, bus.out_ch},
            {22'b0, 1'b0, 1'b0, 8'h00, 2'd0});
        drive(1, 4'b0010, 32'h0000_2014, 1);
        #1;
        chk("lock_rst_arb_ready", 32'(bus.in_ready), 32'h2);
        tick();
        chk("lock_rst_arb_out", {22'b0, bus.out_valid, bus.out_data, bus.out_ch}, {22'b0, 1'b1, 8'h20, 2'd1});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
